// File: rtl/fifo_wptr_full.sv
// Write-side pointer/full stage of the async FIFO (write clock domain).
// Define WPTR_ALMOST_FULL_EN to add the registered o_walmost_full flag.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_winc,
    input  logic [ADDR_WIDTH:0]   i_rptr_gray,
    output logic                  o_wen,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [ADDR_WIDTH:0]   o_wptr_gray,
`ifdef WPTR_ALMOST_FULL_EN
    output logic                  o_walmost_full,
`endif
    output logic                  o_wfull
);

    localparam int A = ADDR_WIDTH;

    if (ADDR_WIDTH < 2) begin : g_bad_aw
        $error("ADDR_WIDTH must be >= 2");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_ss
        $error("SYNC_STAGES must be 2 or 3");
    end
    if (AFULL_MARGIN < 0 || AFULL_MARGIN > 2**ADDR_WIDTH) begin : g_bad_am
        $error("AFULL_MARGIN out of range");
    end

    logic [A:0] wbin;
    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic [A:0] rq [SYNC_STAGES];
    logic [A:0] rq2;
    logic [A:0] full_ptr;
    logic       accept;

    assign accept     = i_winc & ~o_wfull;
    assign o_wen      = accept & i_rstn;
    assign wbin_next  = wbin + {{A{1'b0}}, accept};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign o_waddr    = wbin[A-1:0];
    assign rq2        = rq[SYNC_STAGES-1];
    // Full when the writer is exactly one lap ahead of the synced reader.
    assign full_ptr   = {~rq2[A:A-1], rq2[A-2:0]};

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wbin        <= '0;
            o_wptr_gray <= '0;
            o_wfull     <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            o_wptr_gray <= wgray_next;
            o_wfull     <= (wgray_next == full_ptr);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int k = 0; k < SYNC_STAGES; k++) rq[k] <= '0;
        end else begin
            rq[0] <= i_rptr_gray;
            for (int k = 1; k < SYNC_STAGES; k++) rq[k] <= rq[k-1];
        end
    end

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [A:0] AFULL_TH = (A+1)'(2**A - AFULL_MARGIN);

    logic [A:0] rbin_sync;
    logic [A:0] occ_next;

    always_comb begin
        rbin_sync    = '0;
        rbin_sync[A] = rq2[A];
        for (int i = A - 1; i >= 0; i--) begin
            rbin_sync[i] = rbin_sync[i+1] ^ rq2[i];
        end
    end

    assign occ_next = wbin_next - rbin_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_walmost_full <= 1'b0;
        end else begin
            o_walmost_full <= (occ_next >= AFULL_TH);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_WIDTH=4, SYNC_STAGES=2).
// Covers reset, fill to full, release, wrap, mid-op reset, almost-full.
module tb_fifo_wptr_full;

    logic       clk;
    logic       rstn;
    logic       winc;
    logic [4:0] rptr_gray;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       wfull;
`ifdef WPTR_ALMOST_FULL_EN
    logic       walmost_full;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0] gtab [17] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00010,
        5'b00110, 5'b00111, 5'b00101, 5'b00100,
        5'b01100, 5'b01101, 5'b01111, 5'b01110,
        5'b01010, 5'b01011, 5'b01001, 5'b01000,
        5'b11000
    };

    fifo_wptr_full #(
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2),
        .AFULL_MARGIN(2)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_winc        (winc),
        .i_rptr_gray   (rptr_gray),
        .o_wen         (wen),
        .o_waddr       (waddr),
        .o_wptr_gray   (wptr_gray),
`ifdef WPTR_ALMOST_FULL_EN
        .o_walmost_full(walmost_full),
`endif
        .o_wfull       (wfull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] wb;
        rstn      = 1'b0;
        winc      = 1'b1;
        rptr_gray = 5'b00000;

        // Reset held 3 edges with a write request pending
        repeat (3) tick();
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_gray", 32'(wptr_gray), 32'd0);
        chk("rst_full", 32'(wfull), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);

        // Fill
        rstn = 1'b1;
        #1;
        chk("fill_wen0", 32'(wen), 32'd1);
        chk("fill_waddr0", 32'(waddr), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("fill_waddr", 32'(waddr), 32'(i % 16));
            chk("fill_gray", 32'(wptr_gray), 32'(gtab[i]));
            chk("fill_full", 32'(wfull), 32'(i == 16));
        end
        chk("full_gray", 32'(wptr_gray), 32'b11000);
        chk("full_wen", 32'(wen), 32'd0);
        tick();
        chk("full_hold_gray", 32'(wptr_gray), 32'b11000);
        chk("full_hold_addr", 32'(waddr), 32'd0);
        chk("full_hold_flag", 32'(wfull), 32'd1);

        // Release: reader advances by one
        winc      = 1'b0;
        rptr_gray = 5'b00001;
        tick();
        chk("rel_e1", 32'(wfull), 32'd1);
        tick();
        chk("rel_e2", 32'(wfull), 32'd1);
        tick();
        chk("rel_e3", 32'(wfull), 32'd0);
        chk("rel_wen", 32'(wen), 32'd0);

        // Wrap: reader trails writer by 4
        wb        = 5'd16;
        rptr_gray = gray(5'd12);
        repeat (3) tick();
        chk("wrap_pre_full", 32'(wfull), 32'd0);
        winc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            wb = wb + 5'd1;
            chk("wrap_addr", 32'(waddr), 32'(wb[3:0]));
            chk("wrap_gray", 32'(wptr_gray), 32'(gray(wb)));
            chk("wrap_full", 32'(wfull), 32'd0);
            if (wb == 5'd31) chk("wrap_g31", 32'(wptr_gray), 32'b10000);
            if (wb == 5'd0) chk("wrap_g0", 32'(wptr_gray), 32'b00000);
            rptr_gray = gray(wb - 5'd4);
        end

        // Mid-operation reset
        for (int i = 0; i < 10; i++) begin
            tick();
            wb = wb + 5'd1;
            rptr_gray = gray(wb - 5'd4);
        end
        chk("mid_pre_addr", 32'(waddr), 32'(wb[3:0]));
        rstn = 1'b0;
        #1;
        chk("mid_rst_wen", 32'(wen), 32'd0);
        tick();
        chk("mid_rst_addr", 32'(waddr), 32'd0);
        chk("mid_rst_gray", 32'(wptr_gray), 32'd0);
        chk("mid_rst_full", 32'(wfull), 32'd0);
        rstn      = 1'b1;
        rptr_gray = 5'b00000;
        #1;
        chk("mid_wen", 32'(wen), 32'd1);
        chk("mid_addr0", 32'(waddr), 32'd0);
        tick();
        chk("mid_addr1", 32'(waddr), 32'd1);
        chk("mid_gray1", 32'(wptr_gray), 32'b00001);

`ifdef WPTR_ALMOST_FULL_EN
        // Almost full from the 14th accept
        rstn = 1'b0;
        tick();
        chk("af_rst", 32'(walmost_full), 32'd0);
        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("af_flag", 32'(walmost_full), 32'(k >= 14));
            chk("af_full", 32'(wfull), 32'(k == 16));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
